dcache_ctrl: RTL

- Direct-mapped, write-back, write-allocate data cache controller.
- Sits between the CPU load/store stage and the 128-bit line-based data memory.
- Acts as the initiator of that memory's req/ready protocol: issues 16-byte line refills and dirty-line write-backs.
- Serves 32-bit word accesses with byte enables to the CPU.

---
 rtl/dcache_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate data cache controller
module dcache_ctrl #(
  parameter int NUM_LINES = 64,
  parameter int ADDR_WIDTH = 32,
  localparam int INDEX_W = $clog2(NUM_LINES),
  localparam int TAG_W = ADDR_WIDTH - 4 - INDEX_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [31:0]           cpu_wdata,
  input  logic [3:0]            cpu_be,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_ready,
  output logic                  cpu_busy,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [127:0]          mem_wdata,
  input  logic [127:0]          mem_rdata,
  input  logic                  mem_ready
);
  typedef enum logic [2:0] {IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT} state_t;
  state_t state;
  logic [NUM_LINES-1:0] valid, dirty;
  logic [TAG_W-1:0] tag_arr [NUM_LINES];
  logic [127:0] data_arr [NUM_LINES];
  logic [TAG_W-1:0] r_tag;
  logic [INDEX_W-1:0] r_idx;
  logic [1:0] r_word;
  logic r_we;
  logic [31:0] r_wdata;
  logic [3:0] r_be;
  logic hit;
  logic [127:0] line, merged;
  logic [31:0] fill_addr;
  logic unused_lsb;
  assign unused_lsb = ^cpu_addr[1:0];
  assign line = data_arr[r_idx];
  assign hit = valid[r_idx] && tag_arr[r_idx] == r_tag;
  assign fill_addr = 32'({r_tag, r_idx, 4'h0});
  assign cpu_ready = state == LOOKUP && hit;
  assign cpu_rdata = cpu_ready ? line[32*r_word +: 32] : '0;
  assign cpu_busy = state != IDLE;
  assign mem_req = state == WB_REQ || state == FILL_REQ;
  always_comb begin
    merged = line;
    for (int i = 0; i < 4; i++)
      if (r_be[i]) merged[32*r_word + 8*i +: 8] = r_wdata[8*i +: 8];
  end
  // tag/data arrays carry no reset so they can map onto RAM
  always_ff @(posedge clk) begin
    if (state == LOOKUP && hit && r_we) data_arr[r_idx] <= merged;
    else if (state == FILL_WAIT && mem_ready) begin
      data_arr[r_idx] <= mem_rdata;
      tag_arr[r_idx] <= r_tag;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (cpu_req) begin
          r_tag <= cpu_addr[ADDR_WIDTH-1 -: TAG_W];
          r_idx <= cpu_addr[INDEX_W+3:4];
          r_word <= cpu_addr[3:2];
          r_we <= cpu_we;
          r_wdata <= cpu_wdata;
          r_be <= cpu_be;
          state <= LOOKUP;
        end
        LOOKUP: if (hit) begin
          if (r_we) dirty[r_idx] <= 1'b1;
          state <= IDLE;
        end else if (valid[r_idx] && dirty[r_idx]) begin
          mem_we <= 1'b1;
          mem_addr <= 32'({tag_arr[r_idx], r_idx, 4'h0});
          mem_wdata <= line;
          state <= WB_REQ;
        end else begin
          mem_we <= 1'b0;
          mem_addr <= fill_addr;
          state <= FILL_REQ;
        end
        WB_REQ: state <= WB_WAIT;
        WB_WAIT: if (mem_ready) begin
          dirty[r_idx] <= 1'b0;
          mem_we <= 1'b0;
          mem_addr <= fill_addr;
          state <= FILL_REQ;
        end
        FILL_REQ: state <= FILL_WAIT;
        FILL_WAIT: if (mem_ready) begin
          valid[r_idx] <= 1'b1;
          dirty[r_idx] <= 1'b0;
          state <= LOOKUP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
